// File: rtl/dot_channel_seq_pkg.sv
// Shared definitions for the dot channel sequencer.
// Contents:
//   state_t   - sequencer FSM states
//   DATA_LEN  - default width of a dot channel result
//   IDX_*     - field positions of {phase, cs} inside feat_addr / res_idx
//   pack_idx  - builds a {phase, cs} tag
package dot_channel_seq_pkg;

  localparam int DATA_LEN   = 16;

  localparam int IDX_CS_LSB = 0;
  localparam int IDX_CS_W   = 4;
  localparam int IDX_PH_LSB = 4;
  localparam int IDX_PH_W   = 3;
  localparam int IDX_W      = IDX_CS_W + IDX_PH_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RUN   = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] pack_idx(input logic [IDX_PH_W-1:0] phase,
                                                input logic [IDX_CS_W-1:0] cs);
    logic [IDX_W-1:0] idx;
    idx = '0;
    idx[IDX_PH_LSB +: IDX_PH_W] = phase;
    idx[IDX_CS_LSB +: IDX_CS_W] = cs;
    return idx;
  endfunction

endpackage

// File: rtl/dc_seq_idx_cnt.sv
// (phase, cs) index counter for the dot channel sequencer.
// cs is the inner index, phase the outer one.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - return both indices to 0
//   adv         - step to the next (phase, cs) pair
//   cs, phase   - current indices (registered)
//   last        - current pair is (NUM_PHASE-1, NUM_CS-1)
module dc_seq_idx_cnt
  import dot_channel_seq_pkg::*;
#(
  parameter int NUM_CS    = 12,
  parameter int NUM_PHASE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                adv,
  output logic [IDX_CS_W-1:0] cs,
  output logic [IDX_PH_W-1:0] phase,
  output logic                last
);

  logic cs_wrap;

  assign cs_wrap = (cs == IDX_CS_W'(NUM_CS - 1));
  assign last    = cs_wrap && (phase == IDX_PH_W'(NUM_PHASE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs    <= '0;
      phase <= '0;
    end else if (clr) begin
      cs    <= '0;
      phase <= '0;
    end else if (adv) begin
      if (cs_wrap) begin
        cs    <= '0;
        phase <= phase + 1'b1;
      end else begin
        cs    <= cs + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_channel_seq.sv
// Sequencer for one 36-lane dot channel. Each job walks every (phase, cs)
// pair, waits for the feature vector, holds the channel loads until it
// reports valid, captures the result and hands it downstream.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, abort          - job start pulse / synchronous cancel
//   busy, done, err       - job status (err is sticky until next start)
//   feat_addr, feat_valid - feature vector request / upstream data ready
//   ch_ws_load, ch_dc_load, ch_cs, ch_phase, ch_valid, ch_q - dot channel
//   res_valid, res_ready, res_data, res_idx - result stream
module dot_channel_seq
  import dot_channel_seq_pkg::*;
#(
  parameter int NUM_CS    = 12,
  parameter int NUM_PHASE = 8,
  parameter int TIMEOUT   = 16,
  parameter int DATA_W    = DATA_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    feat_addr,
  input  logic                feat_valid,
  output logic                ch_ws_load,
  output logic                ch_dc_load,
  output logic [IDX_CS_W-1:0] ch_cs,
  output logic [IDX_PH_W-1:0] ch_phase,
  input  logic                ch_valid,
  input  logic [DATA_W-1:0]   ch_q,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic [IDX_W-1:0]    res_idx
);

  state_t state, state_nxt;

  logic [7:0] tmo_cnt, tmo_nxt;
  logic       load, load_nxt;
  logic       busy_nxt, done_nxt, err_nxt, rv_nxt;
  logic       cap, clr, adv, last;

  logic [IDX_CS_W-1:0] cs;
  logic [IDX_PH_W-1:0] phase;

  dc_seq_idx_cnt #(
    .NUM_CS    (NUM_CS),
    .NUM_PHASE (NUM_PHASE)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (adv),
    .cs    (cs),
    .phase (phase),
    .last  (last)
  );

  // Counters are registered, so these follow them without extra delay.
  assign ch_cs      = cs;
  assign ch_phase   = phase;
  assign feat_addr  = pack_idx(phase, cs);
  assign ch_ws_load = load;
  assign ch_dc_load = load;

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = err;
    load_nxt  = load;
    rv_nxt    = res_valid;
    tmo_nxt   = tmo_cnt;
    cap       = 1'b0;
    clr       = 1'b0;
    adv       = 1'b0;
    // Abort also masks a start arriving in the same cycle.
    if (abort) begin
      state_nxt = ST_IDLE;
      busy_nxt  = 1'b0;
      load_nxt  = 1'b0;
      rv_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            clr       = 1'b1;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
        ST_FETCH: begin
          load_nxt = 1'b0;
          if (feat_valid) begin
            load_nxt  = 1'b1;
            tmo_nxt   = '0;
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          load_nxt = 1'b1;
          tmo_nxt  = tmo_cnt + 8'd1;
          // ch_valid takes precedence over the timeout terminal count.
          if (ch_valid) begin
            cap       = 1'b1;
            rv_nxt    = 1'b1;
            load_nxt  = 1'b0;
            state_nxt = ST_EMIT;
          end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
            err_nxt   = 1'b1;
            load_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        ST_EMIT: begin
          // Loads stay low here so the channel restarts its lane counter.
          load_nxt = 1'b0;
          if (res_valid && res_ready) begin
            rv_nxt = 1'b0;
            if (last) begin
              state_nxt = ST_FIN;
            end else begin
              adv       = 1'b1;
              state_nxt = ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          load_nxt  = 1'b0;
          rv_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_nxt;
      load      <= load_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      res_valid <= rv_nxt;
      if (cap) begin
        res_data <= ch_q;
        res_idx  <= pack_idx(phase, cs);
      end
    end
  end

endmodule
